// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: steps a shared 4-bit vector through all 16 combinations,
// waits SETTLE_CYCLES per vector, samples two function outputs and builds both
// truth tables plus a mismatch count and the lowest mismatching vector.
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [3:0]  vec,
  input  logic        e_in,
  input  logic        m_in,
  output logic [15:0] tt_e,
  output logic [15:0] tt_m,
  output logic [4:0]  mismatch_cnt,
  output logic        any_mismatch,
  output logic [3:0]  first_mismatch
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Last settle count before the vector is considered stable.
  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;

  // Sweep sequencer: owns the vector, settle counter and all captured results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      vec            <= 4'd0;
      tt_e           <= 16'h0000;
      tt_m           <= 16'h0000;
      mismatch_cnt   <= 5'd0;
      any_mismatch   <= 1'b0;
      first_mismatch <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          // Results from the previous sweep stay visible until a new start.
          if (start) begin
            vec            <= 4'd0;
            cnt            <= 4'd0;
            tt_e           <= 16'h0000;
            tt_m           <= 16'h0000;
            mismatch_cnt   <= 5'd0;
            any_mismatch   <= 1'b0;
            first_mismatch <= 4'd0;
            state          <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == CNT_LAST) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        SAMPLE: begin
          tt_e[vec] <= e_in;
          tt_m[vec] <= m_in;
          if (e_in != m_in) begin
            mismatch_cnt <= mismatch_cnt + 5'd1;
            if (!any_mismatch) begin
              first_mismatch <= vec;
              any_mismatch   <= 1'b1;
            end
          end
          // vec parks at 15 after the last sample rather than wrapping to 0.
          if (vec == 4'd15) begin
            state <= DONE;
          end else begin
            vec   <= vec + 4'd1;
            cnt   <= 4'd0;
            state <= SETTLE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status flags decode straight from the state register; no input feeds them.
  assign busy = (state == SETTLE) || (state == SAMPLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Testbench for truth_table_sweeper: three instances (S=2, S=1, S=5) driven by
// truth-table function models; the S=1 and S=5 models delay their output by S
// cycles. Expected results are derived from the tables with plain arithmetic.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // index 0: S=2, index 1: S=1, index 2: S=5
  logic        start_s [3];
  logic        busy_s  [3];
  logic        done_s  [3];
  logic [3:0]  vec_s   [3];
  logic        e_s     [3];
  logic        m_s     [3];
  logic [15:0] tte_s   [3];
  logic [15:0] ttm_s   [3];
  logic [4:0]  mc_s    [3];
  logic        any_s   [3];
  logic [3:0]  fm_s    [3];

  // Functions under comparison, as truth tables: bit i = f(vec=i)
  logic [15:0] fa = 16'h0000;
  logic [15:0] fb = 16'h0000;

  // Delay lines for the slow function models
  logic [7:0] pe1 = 8'h00, pm1 = 8'h00, pe5 = 8'h00, pm5 = 8'h00;

  int tests = 0;
  int fails = 0;

  assign e_s[0] = fa[vec_s[0]];
  assign m_s[0] = fb[vec_s[0]];
  assign e_s[1] = pe1[0];
  assign m_s[1] = pm1[0];
  assign e_s[2] = pe5[4];
  assign m_s[2] = pm5[4];

  always @(posedge clk) begin
    pe1 <= {pe1[6:0], fa[vec_s[1]]};
    pm1 <= {pm1[6:0], fb[vec_s[1]]};
    pe5 <= {pe5[6:0], fa[vec_s[2]]};
    pm5 <= {pm5[6:0], fb[vec_s[2]]};
  end

  truth_table_sweeper #(.SETTLE_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .vec(vec_s[0]), .e_in(e_s[0]), .m_in(m_s[0]), .tt_e(tte_s[0]), .tt_m(ttm_s[0]),
    .mismatch_cnt(mc_s[0]), .any_mismatch(any_s[0]), .first_mismatch(fm_s[0]));

  truth_table_sweeper #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .vec(vec_s[1]), .e_in(e_s[1]), .m_in(m_s[1]), .tt_e(tte_s[1]), .tt_m(ttm_s[1]),
    .mismatch_cnt(mc_s[1]), .any_mismatch(any_s[1]), .first_mismatch(fm_s[1]));

  truth_table_sweeper #(.SETTLE_CYCLES(5)) dut5 (
    .clk(clk), .rst(rst), .start(start_s[2]), .busy(busy_s[2]), .done(done_s[2]),
    .vec(vec_s[2]), .e_in(e_s[2]), .m_in(m_s[2]), .tt_e(tte_s[2]), .tt_m(ttm_s[2]),
    .mismatch_cnt(mc_s[2]), .any_mismatch(any_s[2]), .first_mismatch(fm_s[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: results follow directly from the two truth tables.
  task automatic check_results(input int d, input string tag);
    logic [15:0] diff;
    int first;
    diff  = fa ^ fb;
    first = 0;
    for (int i = 15; i >= 0; i--) if (diff[i]) first = i;
    chk({tag, "_tt_e"}, 32'(tte_s[d]), 32'(fa));
    chk({tag, "_tt_m"}, 32'(ttm_s[d]), 32'(fb));
    chk({tag, "_cnt"},  32'(mc_s[d]),  32'($countones(diff)));
    chk({tag, "_any"},  32'(any_s[d]), 32'(diff != 16'h0000));
    chk({tag, "_first"}, 32'(fm_s[d]), 32'(first));
    chk({tag, "_vec"},  32'(vec_s[d]), 32'd15);
  endtask

  task automatic check_zero(input int d, input string tag);
    chk({tag, "_busy"}, 32'(busy_s[d]), 32'd0);
    chk({tag, "_done"}, 32'(done_s[d]), 32'd0);
    chk({tag, "_vec"},  32'(vec_s[d]),  32'd0);
    chk({tag, "_tt_e"}, 32'(tte_s[d]),  32'd0);
    chk({tag, "_tt_m"}, 32'(ttm_s[d]),  32'd0);
    chk({tag, "_cnt"},  32'(mc_s[d]),   32'd0);
    chk({tag, "_any"},  32'(any_s[d]),  32'd0);
    chk({tag, "_first"}, 32'(fm_s[d]),  32'd0);
  endtask

  // One sweep: start pulse sampled at edge 0, count edges until done is seen.
  task automatic sweep(input int d, input int exp_done, input bit repulse, input string tag);
    int  n;
    bit  seen;
    @(negedge clk);
    start_s[d] = 1'b1;
    @(posedge clk);
    #1 start_s[d] = 1'b0;
    chk({tag, "_busy_run"}, 32'(busy_s[d]), 32'd1);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      @(posedge clk);
      n++;
      #1;
      start_s[d] = repulse && (n == 9 || n == 29);
      if (done_s[d]) seen = 1'b1;
    end
    start_s[d] = 1'b0;
    chk({tag, "_done_edge"}, 32'(n), 32'(exp_done));
    chk({tag, "_busy_done"}, 32'(busy_s[d]), 32'd0);
    check_results(d, tag);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 32'(done_s[d]), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_results(d, {tag, "_hold"});
  endtask

  initial begin
    int n;
    int ndone;
    int dq[$];
    for (int d = 0; d < 3; d++) start_s[d] = 1'b0;

    // Reset state
    #12;
    for (int d = 0; d < 3; d++) check_zero(d, "reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero(0, "idle_after_reset");

    // Identical functions: A = B = vec[3] & vec[0]
    for (int i = 0; i < 16; i++) begin
      fa[i] = i[3] & i[0];
      fb[i] = i[3] & i[0];
    end
    sweep(0, 48, 1'b0, "same");
    chk("same_tt_const", 32'(tte_s[0]), 32'h0000AA00);

    // A = (vec==5), B = 0
    fa = 16'h0000; fb = 16'h0000;
    for (int i = 0; i < 16; i++) fa[i] = (i == 5);
    sweep(0, 48, 1'b0, "one_diff");
    chk("one_diff_first_const", 32'(fm_s[0]), 32'd5);

    // A = vec[0], B = ~A
    for (int i = 0; i < 16; i++) begin
      fa[i] = i[0];
      fb[i] = ~i[0];
    end
    sweep(0, 48, 1'b0, "all_diff");
    chk("all_diff_cnt_const", 32'(mc_s[0]), 32'd16);

    // start re-pulsed mid-sweep is ignored
    fa = 16'($urandom); fb = 16'($urandom);
    sweep(0, 48, 1'b1, "repulse");

    // Reset while vec=7: immediate clear, no done, then a clean sweep
    fa = 16'($urandom); fb = fa ^ 16'($urandom);
    @(negedge clk);
    start_s[0] = 1'b1;
    @(posedge clk);
    #1 start_s[0] = 1'b0;
    n = 0;
    while (vec_s[0] != 4'd7 && n < 100) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk("mid_reset_reach7", 32'(vec_s[0]), 32'd7);
    #2 rst = 1'b1;
    #1;
    check_zero(0, "mid_reset");
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (done_s[0]) ndone++;
    end
    chk("mid_reset_no_done", 32'(ndone), 32'd0);
    sweep(0, 48, 1'b0, "after_reset");

    // start held high: done at edges 48, 98, 148
    fa = 16'($urandom); fb = 16'($urandom);
    @(negedge clk);
    start_s[0] = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 149; k++) begin
      @(posedge clk);
      #1;
      if (done_s[0]) dq.push_back(k);
    end
    start_s[0] = 1'b0;
    chk("held_ndone", 32'(dq.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("held_done_%0d", k), 32'(k < dq.size() ? dq[k] : -1), 32'(48 + 50 * k));
    repeat (2) @(posedge clk);
    #1;
    check_results(0, "held");

    // Random tables on the default instance
    for (int r = 0; r < 4; r++) begin
      fa = 16'($urandom);
      fb = (r == 0) ? fa : fa ^ 16'($urandom);
      sweep(0, 48, 1'b0, $sformatf("rand%0d", r));
    end

    // Delayed function models with S=1 and S=5
    for (int r = 0; r < 2; r++) begin
      fa = 16'($urandom); fb = 16'($urandom);
      sweep(1, 32, 1'b0, $sformatf("s1_%0d", r));
      fa = 16'($urandom); fb = fa ^ 16'($urandom_range(1, 65535));
      sweep(2, 96, 1'b0, $sformatf("s5_%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
